// File: rtl/l1c_arb_pkg.sv
// rtl/l1c_arb_pkg.sv - shared types and constants for the L1 cache memory arbiter
package l1c_arb_pkg;

    // Bus widths shared with the cache/CPU-wrapper interface
    localparam int DATA_BITS       = 32;
    localparam int CACHE_TYPE_BITS = 3;

    // Words per cache line, i.e. beats in a read transaction
    localparam int READ_BEATS_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_SEL_I = 1'b0,
        GNT_SEL_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker, one-hot grant
module rr_arb2
    import l1c_arb_pkg::*;
(
    input  logic [1:0] req,      // bit 0 = I-cache, bit 1 = D-cache
    input  gnt_e       last_gnt,
    output logic [1:0] gnt
);

    // On a tie the requester that was not granted last time wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == GNT_SEL_I) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// rtl/l1c_mem_arbiter.sv - shares one CPU-wrapper memory port between I- and D-cache
module l1c_mem_arbiter
    import l1c_arb_pkg::*;
#(
    parameter int READ_BEATS = READ_BEATS_DEF,
    parameter int CNT_BITS   = 3
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       I_req,
    input  logic [DATA_BITS-1:0]       I_addr,
    input  logic                       I_write,
    input  logic [DATA_BITS-1:0]       I_in,
    input  logic [CACHE_TYPE_BITS-1:0] I_type,
    output logic [DATA_BITS-1:0]       I_out,
    output logic                       I_wait,

    input  logic                       D_req,
    input  logic [DATA_BITS-1:0]       D_addr,
    input  logic                       D_write,
    input  logic [DATA_BITS-1:0]       D_in,
    input  logic [CACHE_TYPE_BITS-1:0] D_type,
    output logic [DATA_BITS-1:0]       D_out,
    output logic                       D_wait,

    output logic                       M_req,
    output logic [DATA_BITS-1:0]       M_addr,
    output logic                       M_write,
    output logic [DATA_BITS-1:0]       M_in,
    output logic [CACHE_TYPE_BITS-1:0] M_type,
    input  logic [DATA_BITS-1:0]       M_out,
    input  logic                       M_wait
);

    localparam logic [CNT_BITS-1:0] LAST_READ_BEAT = CNT_BITS'(READ_BEATS - 1);

    arb_state_e          r_state;
    logic [CNT_BITS-1:0] r_beat_cnt;
    gnt_e                r_last_gnt;
    logic                r_is_write;

    logic [1:0]          w_gnt;
    logic                w_own_req;
    logic                w_beat;
    logic                w_last;

    rr_arb2 u_rr_arb2 (
        .req      ({D_req, I_req}),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt)
    );

    // Request of the current owner; an owner dropping it aborts the transaction
    always_comb begin
        w_own_req = 1'b0;
        case (r_state)
            GNT_I:   w_own_req = I_req;
            GNT_D:   w_own_req = D_req;
            default: w_own_req = 1'b0;
        endcase
    end

    assign w_beat = w_own_req & ~M_wait;
    assign w_last = r_is_write ? (r_beat_cnt == '0) : (r_beat_cnt == LAST_READ_BEAT);

    // Grant FSM: latch owner and transaction length at grant, count beats, return to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_last_gnt <= GNT_SEL_I;
            r_is_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_gnt[1]) begin
                        r_state    <= GNT_D;
                        r_last_gnt <= GNT_SEL_D;
                        r_is_write <= D_write;
                    end else if (w_gnt[0]) begin
                        r_state    <= GNT_I;
                        r_last_gnt <= GNT_SEL_I;
                        r_is_write <= I_write;
                    end
                end
                GNT_I, GNT_D: begin
                    if (!w_own_req) begin
                        r_state    <= IDLE;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    // Port muxing: owner sees the memory port, the other side just stalls on its own request
    always_comb begin
        M_req   = 1'b0;
        M_addr  = '0;
        M_write = 1'b0;
        M_in    = '0;
        M_type  = '0;
        I_out   = '0;
        D_out   = '0;
        I_wait  = I_req;
        D_wait  = D_req;
        case (r_state)
            GNT_I: begin
                M_req   = I_req;
                M_addr  = I_addr;
                M_write = I_write;
                M_in    = I_in;
                M_type  = I_type;
                I_out   = M_out;
                I_wait  = M_wait;
            end
            GNT_D: begin
                M_req   = D_req;
                M_addr  = D_addr;
                M_write = D_write;
                M_in    = D_in;
                M_type  = D_type;
                D_out   = M_out;
                D_wait  = M_wait;
            end
            default: ;
        endcase
    end

endmodule
